// File: rtl/fsm_vedacao_if.sv
// Bottle-capping stage bus: upstream handshake, magazine refill and stage status.
interface fsm_vedacao_if;
  logic       in_valid;
  logic       cap_load;
  logic       in_ready;
  logic       VD;
  logic       M;
  logic       alarm;
  logic [3:0] caps;
  logic [2:0] crate_cnt;
  logic       crate_done;
  logic [1:0] state;

  modport master (
    output in_valid, cap_load,
    input  in_ready, VD, M, alarm, caps, crate_cnt, crate_done, state
  );

  modport slave (
    input  in_valid, cap_load,
    output in_ready, VD, M, alarm, caps, crate_cnt, crate_done, state
  );
endinterface

// File: rtl/fsm_vedacao.sv
// Capping stage controller: accept bottle, seal for T_VEDA cycles, convey for T_MOVE
// cycles, track cap magazine and crate fill; blocks with an alarm when caps run out.
module fsm_vedacao #(
  parameter int T_VEDA  = 4,
  parameter int T_MOVE  = 2,
  parameter int CAP_MAX = 15,
  parameter int CAIXA_N = 6
) (
  input  logic          clk,
  input  logic          reset,
  fsm_vedacao_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    VEDANDO   = 2'b01,
    SAINDO    = 2'b10,
    SEM_TAMPA = 2'b11
  } state_t;

  localparam logic [7:0] VEDA_LOAD  = 8'(T_VEDA - 1);
  localparam logic [7:0] MOVE_LOAD  = 8'(T_MOVE - 1);
  localparam logic [3:0] CAPS_FULL  = 4'(CAP_MAX);
  localparam logic [2:0] CRATE_LAST = 3'(CAIXA_N - 1);

  state_t     state_reg, state_next;
  logic [7:0] timer_reg, timer_next;
  logic [3:0] caps_reg, caps_next;
  logic [2:0] crate_reg, crate_next;
  logic       done_reg, done_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      timer_reg <= 8'd0;
      caps_reg  <= CAPS_FULL;
      crate_reg <= 3'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      caps_reg  <= caps_next;
      crate_reg <= crate_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    caps_next  = caps_reg;
    crate_next = crate_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = VEDANDO;
          timer_next = VEDA_LOAD;
        end
      end
      VEDANDO: begin
        if (timer_reg == 8'd0) begin
          state_next = SAINDO;
          timer_next = MOVE_LOAD;
          if (caps_reg != 4'd0) caps_next = caps_reg - 4'd1;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      SAINDO: begin
        if (timer_reg == 8'd0) begin
          if (crate_reg == CRATE_LAST) begin
            crate_next = 3'd0;
            done_next  = 1'b1;
          end else begin
            crate_next = crate_reg + 3'd1;
          end
          // A refill landing on the exit edge keeps the stage out of the alarm state.
          if (caps_reg != 4'd0 || bus.cap_load) state_next = IDLE;
          else                                   state_next = SEM_TAMPA;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      SEM_TAMPA: begin
        if (bus.cap_load) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Refill overrides the sealing decrement on the same edge.
    if (bus.cap_load) caps_next = CAPS_FULL;
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.VD         = (state_reg == VEDANDO);
  assign bus.M          = (state_reg == SAINDO);
  assign bus.alarm      = (state_reg == SEM_TAMPA);
  assign bus.caps       = caps_reg;
  assign bus.crate_cnt  = crate_reg;
  assign bus.crate_done = done_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_fsm_vedacao.sv
// Randomised bench: an edge-numbered bottle timeline model predicts each bottle's
// completion; a negedge monitor checks the DUT whenever the conveyor stops.
`timescale 1ns/1ps
module tb_fsm_vedacao;
  localparam int TV   = 4;
  localparam int TM   = 2;
  localparam int CAPM = 15;
  localparam int CN   = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fsm_vedacao_if bus ();

  fsm_vedacao #(
    .T_VEDA (TV),
    .T_MOVE (TM),
    .CAP_MAX(CAPM),
    .CAIXA_N(CN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  always @(posedge clk) edge_no++;

  typedef struct {
    int exit_e;
    int caps;
    int crate;
    bit done;
    bit alarm;
  } exp_t;

  exp_t q[$];

  // Timeline model: edge numbers of the pending seal-end and exit events.
  int dec_e, exit_e, caps_m, crate_m, blk_cnt;
  bit blocked;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    dec_e   = -1;
    exit_e  = -1;
    blocked = 1'b0;
    caps_m  = CAPM;
    crate_m = 0;
    blk_cnt = 0;
  endtask

  // mode: 0 random without extra refills, 1 random with refills, 2 idle upstream, 3 force a bottle
  task automatic drive_step(input int mode);
    int   n;
    bit   idle, v, l;
    exp_t r;
    n    = edge_no + 1;
    idle = (n > exit_e) && !blocked;
    if (mode == 2)                       v = 1'b0;
    else if (mode == 3)                  v = 1'b1;
    else if (idle && bus.in_valid)       v = 1'b1;
    else                                 v = ($urandom_range(0, 2) != 0);
    l = 1'b0;
    if (blocked) begin
      blk_cnt++;
      if (blk_cnt >= 4) begin
        l = 1'b1;
        blk_cnt = 0;
      end
    end else if (mode == 1) begin
      if (n == dec_e)                         l = ($urandom_range(0, 3) == 0);
      else if (n == exit_e && caps_m == 0)    l = ($urandom_range(0, 1) == 0);
      else                                    l = ($urandom_range(0, 59) == 0);
    end
    if (l)               caps_m = CAPM;
    else if (n == dec_e) caps_m = caps_m - 1;
    if (n == exit_e) begin
      crate_m  = (crate_m + 1) % CN;
      blocked  = (caps_m == 0);
      r.exit_e = n;
      r.caps   = caps_m;
      r.crate  = crate_m;
      r.done   = (crate_m == 0);
      r.alarm  = blocked;
      q.push_back(r);
    end else if (blocked && l) begin
      blocked = 1'b0;
    end
    if (idle && v) begin
      dec_e  = n + TV;
      exit_e = n + TV + TM;
    end
    bus.in_valid = v;
    bus.cap_load = l;
  endtask

  task automatic run(input int cycles, input int mode);
    for (int i = 0; i < cycles; i++) begin
      drive_step(mode);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},      int'(bus.state),      0);
    chk({tag, "_in_ready"},   int'(bus.in_ready),   1);
    chk({tag, "_VD"},         int'(bus.VD),         0);
    chk({tag, "_M"},          int'(bus.M),          0);
    chk({tag, "_alarm"},      int'(bus.alarm),      0);
    chk({tag, "_caps"},       int'(bus.caps),       CAPM);
    chk({tag, "_crate_cnt"},  int'(bus.crate_cnt),  0);
    chk({tag, "_crate_done"}, int'(bus.crate_done), 0);
  endtask

  bit mon_en = 1'b0;
  int vd_run = 0;
  int m_run  = 0;
  bit m_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t r;
    bit   m_fell;
    if (mon_en) begin
      if (bus.VD) vd_run++;
      if (bus.M)  m_run++;
      m_fell = m_prev && !bus.M;
      if (bus.crate_done && !m_fell) begin
        checks++;
        failures++;
        $display("FAIL stray_crate_done actual=1 required=0 (edge %0d)", edge_no);
      end
      if (m_fell) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bottle actual=exit_edge_%0d required=no_bottle", edge_no);
        end else begin
          r = q.pop_front();
          chk("exit_edge",  edge_no,               r.exit_e);
          chk("vd_cycles",  vd_run,                TV);
          chk("m_cycles",   m_run,                 TM);
          chk("caps",       int'(bus.caps),        r.caps);
          chk("crate_cnt",  int'(bus.crate_cnt),   r.crate);
          chk("crate_done", int'(bus.crate_done),  int'(r.done));
          chk("alarm",      int'(bus.alarm),       int'(r.alarm));
          chk("in_ready",   int'(bus.in_ready),    int'(!r.alarm));
          chk("state",      int'(bus.state),       r.alarm ? 3 : 0);
          $display("bottle exit_edge=%0d caps=%0d crate_cnt=%0d crate_done=%0d alarm=%0d",
                   edge_no, bus.caps, bus.crate_cnt, bus.crate_done, bus.alarm);
        end
        vd_run = 0;
        m_run  = 0;
      end
      m_prev = bus.M;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.cap_load = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    check_reset_values("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    run(200, 0);
    run(1200, 1);
    run(40, 2);

    // Abort a bottle mid-conveyor with an asynchronous reset.
    run(1, 3);
    run(TV, 2);
    chk("pre_reset_M", int'(bus.M), 1);
    mon_en = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_values("async_reset");
    q.delete();
    model_reset();
    vd_run = 0;
    m_run  = 0;
    m_prev = 1'b0;
    drive_step(3);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #2;

    run(400, 1);
    run(40, 2);
    chk("pending_bottles", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_vedacao.md
FSM_VEDACAO -- requirements
Module: fsm_vedacao

Interface
REQ-001 Parameter T_VEDA, default 4, number of cycles the sealing actuator is held; legal range 1..256.
REQ-002 Parameter T_MOVE, default 2, number of cycles the output conveyor runs per bottle; legal range 1..256.
REQ-003 Parameter CAP_MAX, default 15, cap magazine capacity; legal range 1..15.
REQ-004 Parameter CAIXA_N, default 6, bottles per crate; legal range 2..7.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream filler presents a full bottle; held until accepted.
REQ-008 cap_load  input  1  magazine refilled; one-cycle pulse.
REQ-009 in_ready  output  1  stage can accept a bottle this cycle.
REQ-010 VD  output  1  sealing (capping) actuator drive.
REQ-011 M  output  1  output conveyor motor drive.
REQ-012 alarm  output  1  magazine empty, stage blocked.
REQ-013 caps  output  4  caps remaining in magazine.
REQ-014 crate_cnt  output  3  bottles in current crate, 0..CAIXA_N-1.
REQ-015 crate_done  output  1  one-cycle pulse when a crate completes.
REQ-016 state  output  2  current state encoding.

Function
REQ-017 States SHALL be IDLE=2'b00, VEDANDO=2'b01, SAINDO=2'b10, SEM_TAMPA=2'b11; no other encodings reachable.
REQ-018 in_ready SHALL equal 1 only in IDLE; VD SHALL equal 1 only in VEDANDO; M SHALL equal 1 only in SAINDO; alarm SHALL equal 1 only in SEM_TAMPA (Moore decode of state register).
REQ-019 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; state -> VEDANDO, 8-bit timer loaded T_VEDA-1.
REQ-020 In VEDANDO timer SHALL decrement each cycle; at timer=0 state -> SAINDO, timer loaded T_MOVE-1, caps decremented by 1.
REQ-021 In SAINDO timer SHALL decrement each cycle; at timer=0 crate_cnt increments, and state -> IDLE if caps>0, else SEM_TAMPA.
REQ-022 Latency: bottle accepted at edge k SHALL see VD high for cycles k+1..k+T_VEDA, M high for the next T_MOVE cycles, in_ready high again T_VEDA+T_MOVE+1 cycles after k.
REQ-023 crate_cnt SHALL wrap from CAIXA_N-1 to 0 on increment; crate_done SHALL be registered and high exactly the cycle after that wrap edge.
REQ-024 cap_load=1 SHALL set caps to CAP_MAX in any state; when coinciding with the VEDANDO decrement edge, load wins (caps=CAP_MAX).
REQ-025 In SEM_TAMPA, cap_load SHALL move state to IDLE; in_valid is ignored.
REQ-026 cap_load coinciding with SAINDO exit edge while caps=0 SHALL route state to IDLE, not SEM_TAMPA.
REQ-027 in_valid while not in IDLE SHALL have no effect; upstream holds it.
REQ-028 caps SHALL never underflow; VEDANDO is entered only when caps>0.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, timer=0, caps=CAP_MAX, crate_cnt=0, crate_done=0; hence in_ready=1, VD=0, M=0, alarm=0.
REQ-030 reset asserted mid-VEDANDO or mid-SAINDO SHALL abort the bottle without changing caps or crate_cnt beyond reset values.
REQ-031 After reset release, first accept SHALL be possible on the first rising edge.

Verification
REQ-032 Defaults, one bottle accepted at edge 0 -> VD high cycles 1..4, M high 5..6, in_ready high at 7, caps=14, crate_cnt=1.
REQ-033 Six back-to-back bottles, in_valid held high -> crate_cnt 1..5 then 0, single crate_done pulse, caps=9.
REQ-034 CAP_MAX=2, three bottles -> state SEM_TAMPA after second, alarm=1, third not accepted; cap_load -> IDLE, caps=2, third accepted next edge.
REQ-035 cap_load on the VEDANDO exit edge with caps=5 -> caps=15 (not 14).
REQ-036 reset pulsed during SAINDO -> all outputs at reset values asynchronously, caps=15, crate_cnt=0.
REQ-037 in_valid toggled during VEDANDO/SAINDO -> no extra accept, timing of REQ-032 unchanged.
